// File: rtl/struct.sv
// rtl/struct.sv - shared decode package: opcodes, instruction fields, ID/EX control struct
package id_stage_pkg;

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000,
        OP_ADDI = 6'b000001,
        OP_SUB  = 6'b000010,
        OP_SUBI = 6'b000011,
        OP_MUL  = 6'b000100,
        OP_MULI = 6'b000101,
        OP_OR   = 6'b000110,
        OP_ORI  = 6'b000111,
        OP_AND  = 6'b001000,
        OP_ANDI = 6'b001001,
        OP_XOR  = 6'b001010,
        OP_XORI = 6'b001011,
        OP_LDW  = 6'b001100,
        OP_STW  = 6'b001101,
        OP_BZ   = 6'b001110,
        OP_BEQ  = 6'b001111,
        OP_JR   = 6'b010000,
        OP_HALT = 6'b010001
    } opcode_e;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_e;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic       valid;
        logic       halt;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic [4:0] rd;
    } idex_ctrl_t;

    typedef struct packed {
        logic       defined;
        logic       uses_rs;
        logic       uses_rt;
        idex_ctrl_t ctrl;
    } decode_t;

    // Undefined opcodes come back all-zero, which is exactly a bubble.
    function automatic decode_t decode(input logic [5:0] op,
                                       input logic [4:0] rt_idx,
                                       input logic [4:0] rd_idx);
        decode_t d;
        d              = '0;
        d.defined      = 1'b1;
        d.uses_rs      = 1'b1;
        d.ctrl.valid   = 1'b1;
        case (opcode_e'(op))
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
                d.uses_rt        = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.rd        = rd_idx;
            end
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
                d.ctrl.reg_write = 1'b1;
                d.ctrl.rd        = rt_idx;
            end
            OP_LDW: begin
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.rd         = rt_idx;
            end
            OP_STW: begin
                d.uses_rt        = 1'b1;
                d.ctrl.mem_write = 1'b1;
            end
            OP_BEQ:       d.uses_rt = 1'b1;
            OP_BZ, OP_JR: d.uses_rt = 1'b0;
            OP_HALT: begin
                d.uses_rs   = 1'b0;
                d.ctrl.halt = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 2-read/1-write register file with same-cycle write bypass, R0 reads zero
module regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra0,
    input  logic [4:0]  ra1,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa != 5'd0 && int'(wa) < NREGS) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd0 = '0;
        if (ra0 != 5'd0) begin
            if (we && wa == ra0) begin
                rd0 = wd;
            end else if (int'(ra0) < NREGS) begin
                rd0 = mem[ra0];
            end
        end
    end

    always_comb begin
        rd1 = '0;
        if (ra1 != 5'd0) begin
            if (we && wa == ra1) begin
                rd1 = wd;
            end else if (int'(ra1) < NREGS) begin
                rd1 = mem[ra1];
            end
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage with load-use interlock, flush, halt and ID/EX register
module id_stage
    import id_stage_pkg::*;
#(
    parameter int          NREGS  = 32,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc4,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        if_stall,
    output logic [5:0]  op,
    output logic [31:0] rs,
    output logic [31:0] rt,
    output logic [31:0] i_data_2_ex,
    output logic [31:0] pc4_out_2_ex,
    output logic        mem_read_2_ex,
    output logic        mem_to_reg_2_ex,
    output logic        mem_write_2_ex,
    output logic        reg_write_2_ex,
    output logic [4:0]  rd_add_value_2_ex,
    output logic        valid_2_ex,
    output logic        halt_2_ex
);

    logic [5:0]  op_f;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [15:0] imm_f;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    decode_t     dec;
    logic        hazard;
    logic        load_instr;
    state_e      state_q;
    state_e      state_d;

    idex_ctrl_t  ctrl_q;
    logic [5:0]  op_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [31:0] imm_q;
    logic [31:0] pc4_q;

    assign op_f   = if_instr[OP_MSB:OP_LSB];
    assign rs_idx = if_instr[RS_MSB:RS_LSB];
    assign rt_idx = if_instr[RT_MSB:RT_LSB];
    assign rd_idx = if_instr[RD_MSB:RD_LSB];
    assign imm_f  = if_instr[IMM_MSB:IMM_LSB];
    assign dec    = decode(op_f, rt_idx, rd_idx);

    regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra0 (rs_idx),
        .ra1 (rt_idx),
        .rd0 (rs_val),
        .rd1 (rt_val),
        .we  (wb_en),
        .wa  (wb_addr),
        .wd  (wb_data)
    );

    // Only registers the decoding instruction really reads can create a load-use hazard.
    assign hazard = if_valid && dec.defined && ctrl_q.valid && ctrl_q.mem_read &&
                    (ctrl_q.rd != 5'd0) &&
                    ((dec.uses_rs && rs_idx == ctrl_q.rd) ||
                     (dec.uses_rt && rt_idx == ctrl_q.rd));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        if_stall   = 1'b0;
        load_instr = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    load_instr = 1'b0;
                end else if (hazard) begin
                    if_stall = 1'b1;
                end else if (if_valid && dec.defined) begin
                    load_instr = 1'b1;
                    if (dec.ctrl.halt) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: if_stall = 1'b1;
            default:   state_d  = ST_RUN;
        endcase
    end

    // Bubbles zero everything except pc4, which simply holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            op_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            imm_q  <= '0;
            pc4_q  <= RST_PC;
        end else if (load_instr) begin
            ctrl_q <= dec.ctrl;
            op_q   <= op_f;
            rs_q   <= rs_val;
            rt_q   <= rt_val;
            imm_q  <= {{16{imm_f[15]}}, imm_f};
            pc4_q  <= if_pc4;
        end else begin
            ctrl_q <= '0;
            op_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            imm_q  <= '0;
        end
    end

    assign op                = op_q;
    assign rs                = rs_q;
    assign rt                = rt_q;
    assign i_data_2_ex       = imm_q;
    assign pc4_out_2_ex      = pc4_q;
    assign mem_read_2_ex     = ctrl_q.mem_read;
    assign mem_to_reg_2_ex   = ctrl_q.mem_to_reg;
    assign mem_write_2_ex    = ctrl_q.mem_write;
    assign reg_write_2_ex    = ctrl_q.reg_write;
    assign rd_add_value_2_ex = ctrl_q.rd;
    assign valid_2_ex        = ctrl_q.valid;
    assign halt_2_ex         = ctrl_q.halt;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        if_stall;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] i_data_2_ex;
    logic [31:0] pc4_out_2_ex;
    logic        mem_read_2_ex;
    logic        mem_to_reg_2_ex;
    logic        mem_write_2_ex;
    logic        reg_write_2_ex;
    logic [4:0]  rd_add_value_2_ex;
    logic        valid_2_ex;
    logic        halt_2_ex;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage #(
        .NREGS  (32),
        .RST_PC (RST_PC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .if_valid          (if_valid),
        .if_instr          (if_instr),
        .if_pc4            (if_pc4),
        .flush             (flush),
        .wb_en             (wb_en),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .if_stall          (if_stall),
        .op                (op),
        .rs                (rs),
        .rt                (rt),
        .i_data_2_ex       (i_data_2_ex),
        .pc4_out_2_ex      (pc4_out_2_ex),
        .mem_read_2_ex     (mem_read_2_ex),
        .mem_to_reg_2_ex   (mem_to_reg_2_ex),
        .mem_write_2_ex    (mem_write_2_ex),
        .reg_write_2_ex    (reg_write_2_ex),
        .rd_add_value_2_ex (rd_add_value_2_ex),
        .valid_2_ex        (valid_2_ex),
        .halt_2_ex         (halt_2_ex)
    );

    function automatic logic [31:0] r_ins(input logic [5:0] o, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {o, s, t, d, 11'b0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] o, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc4 = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        chk("rst_valid", 32'(valid_2_ex), 32'd0);
        chk("rst_pc4", pc4_out_2_ex, RST_PC);
        chk("rst_stall", 32'(if_stall), 32'd0);
        chk("rst_regwr", 32'(reg_write_2_ex), 32'd0);
        chk("rst_halt", 32'(halt_2_ex), 32'd0);
        rst = 1'b0;

        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hA;
        tick();
        wb_addr = 5'd2; wb_data = 32'h5;
        tick();
        wb_en = 1'b0;
        chk("idle_bubble", 32'(valid_2_ex), 32'd0);

        if_valid = 1'b1; if_instr = r_ins(6'h00, 5'd1, 5'd2, 5'd3); if_pc4 = 32'h104;
        tick();
        chk("add_op", 32'(op), 32'h0);
        chk("add_rs", rs, 32'hA);
        chk("add_rt", rt, 32'h5);
        chk("add_rd", 32'(rd_add_value_2_ex), 32'd3);
        chk("add_regwr", 32'(reg_write_2_ex), 32'd1);
        chk("add_valid", 32'(valid_2_ex), 32'd1);
        chk("add_pc4", pc4_out_2_ex, 32'h104);

        if_instr = i_ins(6'h03, 5'd1, 5'd4, 16'hFFF5); if_pc4 = 32'h108;
        tick();
        chk("subi_imm", i_data_2_ex, 32'hFFFF_FFF5);
        chk("subi_rd", 32'(rd_add_value_2_ex), 32'd4);
        chk("subi_op", 32'(op), 32'h3);

        if_instr = i_ins(6'h0C, 5'd1, 5'd5, 16'h0008); if_pc4 = 32'h10C;
        tick();
        chk("ldw_mrd", 32'(mem_read_2_ex), 32'd1);
        chk("ldw_m2r", 32'(mem_to_reg_2_ex), 32'd1);
        chk("ldw_rd", 32'(rd_add_value_2_ex), 32'd5);
        chk("ldw_imm", i_data_2_ex, 32'h8);

        if_instr = i_ins(6'h01, 5'd2, 5'd5, 16'h0001); #1;
        chk("addi_rt_dest_nostall", 32'(if_stall), 32'd0);
        if_instr = i_ins(6'h0D, 5'd1, 5'd5, 16'h0000); #1;
        chk("stw_rt_stall", 32'(if_stall), 32'd1);
        if_instr = i_ins(6'h0E, 5'd1, 5'd5, 16'h0000); #1;
        chk("bz_rt_nostall", 32'(if_stall), 32'd0);
        if_instr = r_ins(6'h00, 5'd5, 5'd2, 5'd6); if_pc4 = 32'h110; #1;
        chk("lu_stall", 32'(if_stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(valid_2_ex), 32'd0);
        chk("lu_bubble_mrd", 32'(mem_read_2_ex), 32'd0);
        chk("lu_stall_drop", 32'(if_stall), 32'd0);
        tick();
        chk("lu_add_valid", 32'(valid_2_ex), 32'd1);
        chk("lu_add_rd", 32'(rd_add_value_2_ex), 32'd6);
        chk("lu_add_rt", rt, 32'h5);

        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234_5678;
        if_instr = r_ins(6'h0A, 5'd7, 5'd0, 5'd8);
        tick();
        chk("byp_rs", rs, 32'h1234_5678);
        chk("byp_rt", rt, 32'h0);
        chk("byp_rd", 32'(rd_add_value_2_ex), 32'd8);

        wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        if_instr = r_ins(6'h00, 5'd0, 5'd0, 5'd9);
        tick();
        chk("r0_byp_rs", rs, 32'h0);
        wb_en = 1'b0;
        if_instr = r_ins(6'h06, 5'd7, 5'd0, 5'd10);
        tick();
        chk("r7_kept", rs, 32'h1234_5678);
        chk("r0_kept", rt, 32'h0);

        if_instr = {6'h3F, 26'h0};
        tick();
        chk("undef_valid", 32'(valid_2_ex), 32'd0);
        chk("undef_regwr", 32'(reg_write_2_ex), 32'd0);

        if_instr = i_ins(6'h0C, 5'd1, 5'd5, 16'h0000);
        tick();
        if_instr = r_ins(6'h00, 5'd5, 5'd2, 5'd6); flush = 1'b1; #1;
        chk("flush_stall", 32'(if_stall), 32'd0);
        tick();
        chk("flush_bubble", 32'(valid_2_ex), 32'd0);

        if_instr = {6'h11, 26'h0};
        tick();
        chk("flush_halt", 32'(halt_2_ex), 32'd0);
        chk("flush_halt_stall", 32'(if_stall), 32'd0);
        flush = 1'b0;
        tick();
        chk("halt_out", 32'(halt_2_ex), 32'd1);
        chk("halt_valid", 32'(valid_2_ex), 32'd1);
        chk("halt_stall", 32'(if_stall), 32'd1);
        if_instr = r_ins(6'h00, 5'd1, 5'd2, 5'd3);
        wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'h77;
        tick();
        wb_en = 1'b0;
        chk("halted_halt", 32'(halt_2_ex), 32'd0);
        chk("halted_valid", 32'(valid_2_ex), 32'd0);
        tick(); tick();
        chk("halted_stall", 32'(if_stall), 32'd1);

        rst = 1'b1; #2;
        chk("arst_stall", 32'(if_stall), 32'd0);
        chk("arst_pc4", pc4_out_2_ex, RST_PC);
        rst = 1'b0;
        if_pc4 = 32'h200;
        tick();
        chk("post_rst_valid", 32'(valid_2_ex), 32'd1);
        chk("post_rst_rs_cleared", rs, 32'h0);
        chk("post_rst_pc4", pc4_out_2_ex, 32'h200);

        if_instr = i_ins(6'h0C, 5'd1, 5'd5, 16'h0000);
        tick();
        if_instr = r_ins(6'h00, 5'd5, 5'd2, 5'd6); #1;
        chk("mid_stall", 32'(if_stall), 32'd1);
        rst = 1'b1; #2;
        rst = 1'b0; #1;
        chk("mid_stall_rst", 32'(if_stall), 32'd0);
        tick();
        chk("mid_rst_valid", 32'(valid_2_ex), 32'd1);
        chk("mid_rst_rd", 32'(rd_add_value_2_ex), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of architectural registers (R0 hardwired zero).
REQ-002 SHALL have parameter RST_PC, default 32'h0000_0000, reset value of pc4_out_2_ex.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  if_instr/if_pc4 hold a fetched instruction
- if_instr  in  32  instruction word: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0]
- if_pc4  in  32  PC+4 of if_instr
- flush  in  1  taken branch/jump from EX; squash decode
- wb_en  in  1  writeback strobe
- wb_addr  in  5  writeback register index
- wb_data  in  32  writeback value
- if_stall  out  1  fetch must hold if_instr/if_pc4
- op  out  6  opcode to EX
- rs  out  32  source operand A
- rt  out  32  source operand B / store data
- i_data_2_ex  out  32  sign-extended immediate
- pc4_out_2_ex  out  32  PC+4 to EX
- mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex, reg_write_2_ex  out  1 each  control to EX
- rd_add_value_2_ex  out  5  destination register index
- valid_2_ex  out  1  ID/EX register holds a real instruction
- halt_2_ex  out  1  HALT in ID/EX

Function
REQ-004 SHALL decode opcodes ADD 000000, ADDI 000001, SUB 000010, SUBI 000011, MUL 000100, MULI 000101, OR 000110, ORI 000111, AND 001000, ANDI 001001, XOR 001010, XORI 001011, LDW 001100, STW 001101, BZ 001110, BEQ 001111, JR 010000, HALT 010001.
REQ-005 SHALL set destination to rd field for R-type (even opcodes 000000-001010), rt field for I-type arithmetic and LDW; reg_write_2_ex=1 only for these.
REQ-006 SHALL set mem_read_2_ex=mem_to_reg_2_ex=1 only for LDW, mem_write_2_ex=1 only for STW.
REQ-007 SHALL sign-extend imm[15:0] to i_data_2_ex for every opcode.
REQ-008 SHALL read rs-field register onto rs and rt-field register onto rt; index 0 reads 0.
REQ-009 SHALL bypass: wb_en with wb_addr equal to a read index (non-zero) in the same cycle returns wb_data.
REQ-010 SHALL ignore writes to R0.
REQ-011 SHALL register all EX outputs in one ID/EX stage: latency 1 cycle from accepted if_instr to outputs.
REQ-012 SHALL detect load-use: valid_2_ex & mem_read_2_ex & rd_add_value_2_ex!=0 matching a register actually read (rs always except HALT; rt for R-type, STW, BEQ) -> if_stall=1 (combinational) and bubble loaded.
REQ-013 SHALL define bubble: valid_2_ex=0, all control outputs 0, halt_2_ex=0.
REQ-014 SHALL give flush priority over stall: flush=1 loads bubble, drops current decode, deasserts if_stall.
REQ-015 SHALL load bubble when if_valid=0 or opcode undefined.
REQ-016 SHALL FSM states RUN, HALTED: RUN->HALTED when HALT enters ID/EX without flush in same cycle; HALTED holds if_stall=1, loads bubbles, exits only on rst.
REQ-017 SHALL keep register file writes active in HALTED.

Reset
REQ-018 SHALL on rst asynchronously: state RUN, all ID/EX outputs 0, pc4_out_2_ex=RST_PC, if_stall=0; register file contents also cleared to 0.
REQ-019 SHALL, on rst mid-stall, drop the stalled instruction; first edge after rst release decodes if_instr.

Structure
REQ-020 SHALL place opcode enum, field bit positions and the ID/EX control struct in the shared package in struct.sv.
REQ-021 SHALL instantiate sub-module regfile (2 read, 1 write, bypass, R0 zero).

Verification
REQ-022 SHALL cover: wb R1=0xA, R2=0x5; ADD R3,R1,R2 -> next cycle op=000000, rs=0xA, rt=0x5, rd_add_value_2_ex=3, reg_write_2_ex=1.
REQ-023 SHALL cover: SUBI R4,R1,-11 (imm 0xFFF5) -> i_data_2_ex=0xFFFFFFF5, rd_add_value_2_ex=4.
REQ-024 SHALL cover: LDW R5,8(R1) then ADD R6,R5,R2 -> if_stall=1 one cycle, one bubble, then ADD issues.
REQ-025 SHALL cover: wb_en, wb_addr=7, wb_data=0x12345678 while decoding XOR R8,R7,R0 -> rs=0x12345678, rt=0.
REQ-026 SHALL cover: flush during load-use stall -> bubble, if_stall=0; then HALT -> halt_2_ex=1 for one cycle, if_stall held 1 until rst.
